risc_alu: RTL and testbench

- Registered 32-bit integer ALU for the RISC datapath. Takes two 32-bit operands and a 5-bit opcode and produces a 64-bit result.
- Multiply writes a full 64-bit product. Divide packs the remainder in the high word and the quotient in the low word. Every other operation writes only the low word.
- The result feeds the datapath HI/LO/Z registers one clock after issue.

---
 rtl/risc_alu.sv | 149 ++++++++++++++
 tb/tb_risc_alu.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/risc_alu.sv
// risc_alu: registered integer ALU for the RISC datapath.
//
// Operands are sampled on the rising clk edge when in_valid is high.
// The 2*WIDTH result is available one cycle later.
//   MUL : {H,L} = signed 64-bit product
//   DIV : H = remainder, L = quotient (signed, truncating toward zero)
//   other ops write L only, with H = 0
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-high reset
//   in_valid   issue strobe
//   input_a    operand A (dividend, shift/rotate source)
//   input_b    operand B (divisor, shift/rotate count in b[4:0])
//   opcode     operation select (13..31 reserved -> result 0)
//   alu_result registered result
//   out_valid  one-cycle pulse when alu_result updates
//   flags      {overflow, negative, zero}; exists only when ALU_FLAGS_EN is defined
//
// Optional feature macro: ALU_FLAGS_EN
module risc_alu #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     input_a,
    input  logic [WIDTH-1:0]     input_b,
    input  logic [4:0]           opcode,
    output logic [2*WIDTH-1:0]   alu_result,
`ifdef ALU_FLAGS_EN
    output logic [2:0]           flags,
`endif
    output logic                 out_valid
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0]      W_L  = (SW+1)'(WIDTH);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3,
        OP_SHR  = 5'd4,  OP_SHRA = 5'd5, OP_SHL = 5'd6,  OP_ROR = 5'd7,
        OP_ROL  = 5'd8,  OP_MUL = 5'd9,  OP_DIV = 5'd10, OP_NEG = 5'd11,
        OP_NOT  = 5'd12
    } op_e;

    logic [SW-1:0]           w_sh;
    logic [SW:0]             w_shinv;
    logic [WIDTH-1:0]        w_sum, w_diff, w_neg;
    logic signed [2*WIDTH-1:0] w_prod;
    logic                    w_div0, w_divovf;
    logic signed [WIDTH-1:0] w_dvsr, w_quo, w_rem;
    logic [2*WIDTH-1:0]      w_result;

    logic [2*WIDTH-1:0]      r_result;
    logic                    r_valid;

    assign w_sh    = input_b[SW-1:0];
    assign w_shinv = W_L - {1'b0, w_sh};
    assign w_sum   = input_a + input_b;
    assign w_diff  = input_a - input_b;
    assign w_neg   = ~input_a + 1'b1;
    assign w_prod  = $signed({{WIDTH{input_a[WIDTH-1]}}, input_a}) *
                     $signed({{WIDTH{input_b[WIDTH-1]}}, input_b});

    // The divider never sees a zero divisor or the MIN/-1 pair. Those cases
    // would trap in a software model. Their results are overridden below anyway.
    assign w_div0   = (input_b == '0);
    assign w_divovf = (input_a == MINV) && (input_b == ONES);
    assign w_dvsr   = (w_div0 || w_divovf) ? WIDTH'(1) : $signed(input_b);
    assign w_quo    = $signed(input_a) / w_dvsr;
    assign w_rem    = $signed(input_a) % w_dvsr;

    always_comb begin
        w_result = '0;
        case (opcode)
            OP_ADD:  w_result[WIDTH-1:0] = w_sum;
            OP_SUB:  w_result[WIDTH-1:0] = w_diff;
            OP_AND:  w_result[WIDTH-1:0] = input_a & input_b;
            OP_OR:   w_result[WIDTH-1:0] = input_a | input_b;
            OP_SHR:  w_result[WIDTH-1:0] = input_a >> w_sh;
            OP_SHRA: w_result[WIDTH-1:0] = $signed(input_a) >>> w_sh;
            OP_SHL:  w_result[WIDTH-1:0] = input_a << w_sh;
            // A shift of WIDTH yields 0, so a count of 0 returns a unchanged.
            OP_ROR:  w_result[WIDTH-1:0] = (input_a >> w_sh) | (input_a << w_shinv);
            OP_ROL:  w_result[WIDTH-1:0] = (input_a << w_sh) | (input_a >> w_shinv);
            OP_MUL:  w_result = w_prod;
            OP_DIV: begin
                if (w_div0)
                    w_result = {input_a, ONES};
                else if (w_divovf)
                    w_result = {{WIDTH{1'b0}}, MINV};
                else
                    w_result = {w_rem, w_quo};
            end
            OP_NEG:  w_result[WIDTH-1:0] = w_neg;
            OP_NOT:  w_result[WIDTH-1:0] = ~input_a;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid)
                r_result <= w_result;
        end
    end

    assign alu_result = r_result;
    assign out_valid  = r_valid;

`ifdef ALU_FLAGS_EN
    logic       w_ovf, w_negf, w_zero;
    logic [2:0] r_flags;

    assign w_zero = (w_result == '0);

    always_comb begin
        w_ovf  = 1'b0;
        w_negf = w_result[WIDTH-1];
        case (opcode)
            OP_ADD: w_ovf = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != input_a[WIDTH-1]);
            OP_SUB: w_ovf = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != input_a[WIDTH-1]);
            OP_NEG: w_ovf = (input_a == MINV);
            OP_MUL: w_negf = w_result[2*WIDTH-1];
            OP_DIV: w_ovf = w_div0 || w_divovf;  // negative = quotient sign = L msb
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_flags <= '0;
        else if (in_valid)
            r_flags <= {w_ovf, w_negf, w_zero};
    end

    assign flags = r_flags;
`endif

endmodule

// File: tb/tb_risc_alu.sv
module tb_risc_alu;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] input_a = '0;
    logic [31:0] input_b = '0;
    logic [4:0]  opcode = '0;
    logic [63:0] alu_result;
    logic        out_valid;
`ifdef ALU_FLAGS_EN
    logic [2:0]  flags;
`endif

    int compared = 0;
    int mismatched = 0;

    risc_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .in_valid   (in_valid),
        .input_a    (input_a),
        .input_b    (input_b),
        .opcode     (opcode),
        .alu_result (alu_result),
`ifdef ALU_FLAGS_EN
        .flags      (flags),
`endif
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue at the falling edge, then sample 1 time unit after the capturing edge.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] opc, input logic [63:0] exp);
        @(negedge clk);
        input_a  = a;
        input_b  = b;
        opcode   = opc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check64(tag, alu_result, exp);
        check64({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        // reset state
        #12;
        check64("rst_res", alu_result, 64'd0);
        check64("rst_vld", {63'd0, out_valid}, 64'd0);
`ifdef ALU_FLAGS_EN
        check64("rst_flg", {61'd0, flags}, 64'd0);
`endif
        @(negedge clk);
        clr = 1'b0;

        op("add", 32'd2, 32'd3, 5'd0, 64'h0000000000000005);
        // clr asserted mid-run clears outputs immediately
        #2 clr = 1'b1;
        #1;
        check64("clr_res", alu_result, 64'd0);
        check64("clr_vld", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;

        op("add2", 32'd2, 32'd3, 5'd0, 64'h0000000000000005);
        op("sub",  32'd2, 32'd3, 5'd1, 64'h00000000FFFFFFFF);
        op("and",  32'd12, 32'd17, 5'd2, 64'h0);
`ifdef ALU_FLAGS_EN
        check64("and_flg", {61'd0, flags}, 64'd1);
`endif
        op("or",   32'd12, 32'd17, 5'd3, 64'h1D);
        op("shra", 32'h80000000, 32'd4, 5'd5, 64'h00000000F8000000);
        op("shr",  32'h80000000, 32'd4, 5'd4, 64'h0000000008000000);
        op("shl",  32'd17, 32'd17, 5'd6, 64'h0000000000220000);
        op("ror",  32'd17, 32'd17, 5'd7, 64'h0000000000088000);
        op("rol",  32'd17, 32'd17, 5'd8, 64'h0000000000220000);
        op("shl0", 32'd17, 32'd0, 5'd6, 64'h11);
        op("ror0", 32'd17, 32'd0, 5'd7, 64'h11);
        op("rol0", 32'd17, 32'd0, 5'd8, 64'h11);
        op("shl_hib", 32'd1, 32'h00000025, 5'd6, 64'h20);
        op("ror1", 32'd1, 32'd1, 5'd7, 64'h0000000080000000);
        op("mul",  32'd17, 32'd17, 5'd9, 64'h0000000000000121);
        op("muln", 32'hFFFFFFFA, 32'd5, 5'd9, 64'hFFFFFFFFFFFFFFE2);
        op("div1", 32'd17, 32'd17, 5'd10, 64'h0000000000000001);
        op("div2", 32'hFFFFFFFA, 32'd5, 5'd10, 64'hFFFFFFFFFFFFFFFF);
        op("div3", 32'hFFFFFFEF, 32'hFFFFFFF7, 5'd10, 64'hFFFFFFF800000001);
        op("div4", 32'd8, 32'd24, 5'd10, 64'h0000000800000000);
        op("div0", 32'd8, 32'd0, 5'd10, 64'h00000008FFFFFFFF);
`ifdef ALU_FLAGS_EN
        check64("div0_flg", {61'd0, flags}, 64'd6);
`endif
        op("divovf", 32'h80000000, 32'hFFFFFFFF, 5'd10, 64'h0000000080000000);
`ifdef ALU_FLAGS_EN
        check64("divovf_flg", {61'd0, flags}, 64'd6);
        op("addovf", 32'h7FFFFFFF, 32'd1, 5'd0, 64'h0000000080000000);
        check64("addovf_flg", {61'd0, flags}, 64'd6);
`endif
        op("neg",  32'd8, 32'd3, 5'd11, 64'h00000000FFFFFFF8);
        op("not",  32'd8, 32'd3, 5'd12, 64'h00000000FFFFFFF7);

        // hold: in_valid low keeps the result and drops out_valid
        @(negedge clk);
        in_valid = 1'b0;
        input_a  = 32'd99;
        opcode   = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check64("hold_res", alu_result, 64'h00000000FFFFFFF7);
        check64("hold_vld", {63'd0, out_valid}, 64'd0);

        op("rsvd", 32'd8, 32'd3, 5'd20, 64'h0);

        // issue sampled while clr is high is discarded
        op("pre", 32'd2, 32'd3, 5'd0, 64'h5);
        @(negedge clk);
        input_a = 32'd7; input_b = 32'd1; opcode = 5'd0; in_valid = 1'b1;
        #2 clr = 1'b1;
        @(posedge clk);
        #1;
        check64("rstop_res", alu_result, 64'd0);
        check64("rstop_vld", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check64("rstop_vld2", {63'd0, out_valid}, 64'd0);
        check64("rstop_res2", alu_result, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
